// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider.
// Contents:
//   sdiv_state_t : FSM state encoding (3 bits) IDLE/PREP/ITER/FIX/DONE
//   sdiv_cnt_w() : width of the iteration counter for a given operand width
package seq_signed_divider_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } sdiv_state_t;

  // $clog2(width), kept at least 1 so a degenerate WIDTH=1 still has a counter.
  function automatic int sdiv_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_signed_divider_sdiv_step.sv
// sdiv_step: one radix-2 restoring division iteration, purely combinational.
// Ports:
//   r      in  WIDTH+1  partial remainder (magnitude)
//   q      in  WIDTH    partial quotient / remaining dividend bits
//   dm     in  WIDTH    divisor magnitude
//   r_next out WIDTH+1  remainder after shift and conditional subtract
//   q_next out WIDTH    quotient after shift, new bit in q_next[0]
module sdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dm,
  output logic [WIDTH:0]   r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   dm_ext;
  logic [WIDTH:0]   diff;

  always_comb begin
    // {R,Q} <<= 1 : the top dividend bit still held in Q moves into R.
    r_sh   = (r << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
    q_sh   = q << 1;
    dm_ext = {1'b0, dm};
    diff   = r_sh - dm_ext;
    r_next = r_sh;
    q_next = q_sh;
    if (r_sh >= dm_ext) begin
      r_next = diff;
      q_next = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: multi-cycle signed divider, 2*WIDTH-bit dividend by
// WIDTH-bit divisor, truncating (C-style) quotient and remainder. Restoring
// radix-2 iteration on magnitudes, one quotient bit per cycle.
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready high only while IDLE
//   dividend [2W-1:0]   signed dividend, captured on the accept edge
//   divisor  [W-1:0]    signed divisor, captured on the accept edge
//   out_valid/out_ready result handshake; result held until accepted
//   quot, rem [W-1:0]   signed quotient / remainder (rem sign follows dividend)
//   err_dz, err_ov      divide-by-zero / quotient-overflow, qualified by out_valid
// Latency accept->out_valid: WIDTH+2 cycles normally, 2 cycles for the
// divide-by-zero and precheck-overflow early exits.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               err_dz,
  output logic               err_ov
);

  localparam int              CNT_W    = sdiv_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] Q_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's-complement magnitude; the most negative value maps to 2^(N-1),
  // which is representable unsigned, so no special case is needed.
  function automatic logic [2*WIDTH-1:0] mag_wide(input logic signed [2*WIDTH-1:0] v);
    return v[2*WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] mag_narrow(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
    return neg ? (~m + {{(WIDTH-1){1'b0}}, 1'b1}) : m;
  endfunction

  // Quotient magnitude must fit the signed result range: up to 2^(W-1)-1
  // for a positive result, up to 2^(W-1) for a negative one.
  function automatic logic quot_overflow(input logic neg, input logic [WIDTH-1:0] m);
    return neg ? (m > Q_MIN) : (m >= Q_MIN);
  endfunction

  sdiv_state_t               state;
  logic signed [2*WIDTH-1:0] dvd_p0;
  logic signed [WIDTH-1:0]   dvs_p0;
  logic [WIDTH:0]            r_p1;
  logic [WIDTH-1:0]          q_p1;
  logic [WIDTH-1:0]          dm_p1;
  logic                      sq_p1;
  logic                      sr_p1;
  logic                      early_p1;
  logic [CNT_W-1:0]          cnt_p1;

  logic [2*WIDTH-1:0]        nm;
  logic [WIDTH-1:0]          nm_hi;
  logic [WIDTH-1:0]          nm_lo;
  logic [WIDTH-1:0]          dm;
  logic [WIDTH:0]            r_nx;
  logic [WIDTH-1:0]          q_nx;
  logic [WIDTH-1:0]          quot_fix;
  logic [WIDTH-1:0]          rem_fix;
  logic                      ov_fix;

  assign in_ready = (state == IDLE);

  // Prep stage: magnitudes of the captured operands.
  always_comb begin
    nm    = mag_wide(dvd_p0);
    nm_hi = nm[2*WIDTH-1:WIDTH];
    nm_lo = nm[WIDTH-1:0];
    dm    = mag_narrow(dvs_p0);
  end

  // Iteration stage: one restoring step per cycle.
  sdiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r      (r_p1),
    .q      (q_p1),
    .dm     (dm_p1),
    .r_next (r_nx),
    .q_next (q_nx)
  );

  // Fix-up stage: restore signs and range-check the quotient.
  always_comb begin
    quot_fix = apply_sign(sq_p1, q_p1);
    rem_fix  = apply_sign(sr_p1, r_p1[WIDTH-1:0]);
    ov_fix   = quot_overflow(sq_p1, q_p1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      err_dz    <= 1'b0;
      err_ov    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_p0 <= dividend;
            dvs_p0 <= divisor;
            state  <= PREP;
          end
        end

        PREP: begin
          sq_p1 <= dvd_p0[2*WIDTH-1] ^ dvs_p0[WIDTH-1];
          sr_p1 <= dvd_p0[2*WIDTH-1];
          // Early exits load their result here and still publish it through
          // FIX, so every result leaves from one place.
          if (dvs_p0 == '0) begin
            quot     <= '1;
            rem      <= dvd_p0[WIDTH-1:0];
            err_dz   <= 1'b1;
            early_p1 <= 1'b1;
            state    <= FIX;
          end else if (nm_hi >= dm) begin
            // High half already >= divisor: quotient cannot fit WIDTH bits.
            quot     <= '0;
            rem      <= '0;
            err_ov   <= 1'b1;
            early_p1 <= 1'b1;
            state    <= FIX;
          end else begin
            r_p1     <= {1'b0, nm_hi};
            q_p1     <= nm_lo;
            dm_p1    <= dm;
            cnt_p1   <= CNT_INIT;
            early_p1 <= 1'b0;
            state    <= ITER;
          end
        end

        ITER: begin
          r_p1   <= r_nx;
          q_p1   <= q_nx;
          cnt_p1 <= cnt_p1 - CNT_ONE;
          if (cnt_p1 == CNT_ZERO) begin
            state <= FIX;
          end
        end

        FIX: begin
          if (!early_p1) begin
            if (ov_fix) begin
              quot   <= '0;
              rem    <= '0;
              err_ov <= 1'b1;
            end else begin
              quot <= quot_fix;
              rem  <= rem_fix;
            end
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            err_dz    <= 1'b0;
            err_ov    <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        err_dz;
  logic        err_ov;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .err_dz    (err_dz),
    .err_ov    (err_ov)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [63:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) chk("timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", {63'd0, out_valid}, 64'd0);
    chk("flags_clear", {62'd0, err_dz, err_ov}, 64'd0);
  endtask

  task automatic op(input string tag, input logic [63:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er,
                    input logic edz, input logic eov, input int elat);
    int lat;
    issue(a, b);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_quot"}, {32'd0, quot}, {32'd0, eq});
    chk({tag, "_rem"}, {32'd0, rem}, {32'd0, er});
    chk({tag, "_dz"}, {63'd0, err_dz}, {63'd0, edz});
    chk({tag, "_ov"}, {63'd0, err_ov}, {63'd0, eov});
    take();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=stuck expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic saw_valid;
    logic signed [31:0] x, y;
    logic signed [63:0] p;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_quot", {32'd0, quot}, 64'd0);
    chk("rst_rem", {32'd0, rem}, 64'd0);
    chk("rst_flags", {62'd0, err_dz, err_ov}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic signs: 100/7 = 14 r 2, truncating toward zero.
    op("pp", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34);
    op("np", 64'hFFFF_FFFF_FFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 34);
    op("pn", 64'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0, 34);
    op("nn", 64'hFFFF_FFFF_FFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0, 34);

    // Divide by zero: all-ones quotient, low dividend half as remainder.
    op("dz", 64'h0000_0000_1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 2);
    op("dzneg", 64'hFFFF_FFFF_FFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1'b0, 2);

    // Overflow: precheck path and fix-up path.
    op("ovpre", 64'h0000_0001_0000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 2);
    op("ovmin64", 64'h8000_0000_0000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 2);
    op("ovfix", 64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1, 34);

    // Range boundary: -2^31 / 1 fits exactly; small / most-negative divisor.
    op("qmin", 64'hFFFF_FFFF_8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 34);
    op("dvsmin", 64'd7, 32'h8000_0000, 32'd0, 32'd7, 1'b0, 1'b0, 34);

    // Back-pressure: result held while out_ready is low, new requests ignored.
    issue(64'd1000, 32'd3);
    wait_done(lat);
    chk("hold_lat", 64'(lat), 64'd34);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 64'd55;
      divisor  = 32'd5;
      @(posedge clk);
      #1;
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_quot", {32'd0, quot}, 64'd333);
      chk("hold_rem", {32'd0, rem}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    take();
    op("after_hold", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 34);

    // Reset in the middle of an iteration aborts without a result.
    issue(64'd100, 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("abort_no_result", {63'd0, saw_valid}, 64'd0);
    op("after_abort", 64'd45, 32'd6, 32'd7, 32'd3, 1'b0, 1'b0, 34);

    // Round trip: product of x and y divided by y gives x exactly.
    for (int n = 0; n < 1000; n++) begin
      do x = $signed($urandom); while (x == 0 || x == 32'sh8000_0000);
      do y = $signed($urandom); while (y == 0);
      p = x * y;
      op("rt", p, y, x, 32'd0, 1'b0, 1'b0, 34);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
